pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 49 ++++
 rtl/hazard_stage_reg.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-select
// encoding, the per-stage instruction record and the source-match helpers.
package pipe_pkg;

  // Records are sized for the widest supported register address; narrower
  // addresses are zero-extended on entry, which keeps equality compares exact.
  localparam int MAX_AW = 8;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] rs1;
    logic [MAX_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [MAX_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // True when the producer record will write register src. Register 0 never
  // counts as written when it is hardwired to zero.
  function automatic logic writes_src(stage_rec_t prod, logic [MAX_AW-1:0] src,
                                      logic zero_reg);
    return prod.valid && prod.regwrite && (prod.rd == src) &&
           !(zero_reg && (src == '0));
  endfunction

  // Operand source for one EX read; the younger MEM result wins over WB.
  function automatic fwd_sel_e fwd_select(logic reads, logic [MAX_AW-1:0] src,
                                          stage_rec_t mem, stage_rec_t wb,
                                          logic zero_reg);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (reads) begin
      if (writes_src(mem, src, zero_reg))     sel = FWD_MEM;
      else if (writes_src(wb, src, zero_reg)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record register with synchronous reset and a
// bubble-insert control that loads an empty (valid=0) record.
module hazard_stage_reg
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  // Capture the upstream record, or an empty one on reset / bubble insert.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every stage samples its neighbour's old value on the same edge.
    // NOTE: the record is small control state, so it is cleared on reset; a bubble is just the cleared value.
    if (rst)         q <= BUBBLE;
    else if (bubble) q <= BUBBLE;
    else             q <= d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: load-use stall,
// taken-branch flush and EX operand forwarding from MEM/WB.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam logic ZR = (ZERO_REG != 0);

  stage_rec_t id_rec;
  stage_rec_t ex_rec;
  stage_rec_t mem_rec;
  stage_rec_t wb_rec;
  logic       load_use;
  fwd_sel_e   fwd_a_sel;
  fwd_sel_e   fwd_b_sel;
  logic       unused_fields;

  // Pack the ID-stage inputs into a record, zero-extending register numbers.
  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    id_rec          = BUBBLE;
    id_rec.valid    = id_valid;
    id_rec.rs1      = MAX_AW'(id_rs1);
    id_rec.rs2      = MAX_AW'(id_rs2);
    id_rec.rs1_used = id_rs1_used;
    id_rec.rs2_used = id_rs2_used;
    id_rec.rd       = MAX_AW'(id_rd);
    id_rec.regwrite = id_regwrite;
    id_rec.memread  = id_memread;
  end

  // A load in EX whose result a used ID source needs; a taken branch kills it.
  always_comb begin
    load_use = id_rec.valid && ex_rec.memread &&
               ((id_rec.rs1_used && writes_src(ex_rec, id_rec.rs1, ZR)) ||
                (id_rec.rs2_used && writes_src(ex_rec, id_rec.rs2, ZR)));
    stall    = load_use && !ex_branch_taken;
    flush_id = ex_branch_taken;
    flush_ex = ex_branch_taken;
  end

  // EX operand forwarding selects; an empty EX record reads the register file.
  always_comb begin
    fwd_a_sel = fwd_select(ex_rec.valid && ex_rec.rs1_used, ex_rec.rs1,
                           mem_rec, wb_rec, ZR);
    fwd_b_sel = fwd_select(ex_rec.valid && ex_rec.rs2_used, ex_rec.rs2,
                           mem_rec, wb_rec, ZR);
    fwd_a     = fwd_a_sel;
    fwd_b     = fwd_b_sel;
  end

  hazard_stage_reg u_ex (
    .clk    (clk),
    .rst    (rst),
    .bubble (stall || flush_ex),
    .d      (id_rec),
    .q      (ex_rec)
  );

  hazard_stage_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (ex_rec),
    .q      (mem_rec)
  );

  hazard_stage_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (1'b0),
    .d      (mem_rec),
    .q      (wb_rec)
  );

  // Source fields of the later stages are carried only for visibility.
  assign unused_fields = ^{mem_rec.rs1, mem_rec.rs2, mem_rec.rs1_used,
                           mem_rec.rs2_used, mem_rec.memread,
                           wb_rec.rs1, wb_rec.rs2, wb_rec.rs1_used,
                           wb_rec.rs2_used, wb_rec.memread};

`ifdef HAZ_PERF_CNT_EN
  // Count stall cycles and taken-branch cycles, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)           stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_branch_taken) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  // Counter width only matters when the counters are built.
  localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule
